// File: rtl/mac_feeder_pkg.sv
// rtl/mac_feeder_pkg.sv - shared types and constants for the MAC feeder
package mac_feeder_pkg;

    localparam int BEAT_W       = 64;
    localparam int VEC_BEATS    = 4;
    localparam int VEC_W        = BEAT_W * VEC_BEATS;
    localparam int DEF_READ_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/mac_vec_fifo.sv
// rtl/mac_vec_fifo.sv - vector FIFO between beat staging and the MAC sequencer
// Ports: push_i/push_data_i write side, pop_i/pop_data_o read side (show-ahead),
// full_o/empty_o flags. A push into a full FIFO is taken only when a pop happens
// in the same cycle.
module mac_vec_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_INC;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - assembles 64-bit DMA beats into 256-bit MAC vectors and sequences the MAC array
// Ports: s_valid/s_data/s_last/s_ready beat input; cfg_bias group bias input;
// DMA_channel_0..3 vector out; mac_en/mac_clr/mac_read_en MAC controls;
// bias held per group; busy activity flag; err sticky short-vector flag.
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int READ_LAT   = DEF_READ_LAT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [BEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [15:0]       cfg_bias,
    output logic [BEAT_W-1:0] DMA_channel_0,
    output logic [BEAT_W-1:0] DMA_channel_1,
    output logic [BEAT_W-1:0] DMA_channel_2,
    output logic [BEAT_W-1:0] DMA_channel_3,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              mac_read_en,
    output logic [15:0]       bias,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] LAT_CNT = 4'(READ_LAT);

    logic              rdy_q;
    logic [1:0]        beat_cnt_q;
    logic [BEAT_W-1:0] stage_q [VEC_BEATS];
    logic              err_q;
    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              mac_en_q;
    logic [VEC_W-1:0]  vec_q;
    logic [15:0]       bias_q;

    logic              closes_vec;
    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [VEC_W-1:0]  push_vec;
    logic [VEC_W:0]    fifo_rd_data;

    // Any beat that closes a vector needs a FIFO slot; the others only fill staging.
    assign closes_vec = (beat_cnt_q == 2'd3) || s_last;
    assign s_ready    = rdy_q && (!closes_vec || !fifo_full || fifo_pop);
    assign accept     = s_valid && s_ready;
    assign fifo_push  = accept && closes_vec;

    // Lanes below the current beat come from staging, the current lane straight
    // from s_data, and lanes past a short s_last are zero.
    always_comb begin
        push_vec = '0;
        for (int i = 0; i < VEC_BEATS; i++) begin
            if (2'(i) < beat_cnt_q)       push_vec[i*BEAT_W +: BEAT_W] = stage_q[i];
            else if (2'(i) == beat_cnt_q) push_vec[i*BEAT_W +: BEAT_W] = s_data;
        end
    end

    mac_vec_fifo #(
        .WIDTH (VEC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i ({s_last, push_vec}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < VEC_BEATS; i++) stage_q[i] <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                stage_q[beat_cnt_q] <= s_data;
                beat_cnt_q          <= closes_vec ? 2'd0 : beat_cnt_q + 2'd1;
                if (s_last && beat_cnt_q != 2'd3) err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_rd_data[VEC_W]) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                // The read pulse cycle is the last WAIT cycle; a group already
                // queued goes straight to CLEAR on the following edge.
                if (wait_cnt_q == LAT_CNT) state_d = fifo_empty ? ST_IDLE : ST_CLEAR;
                else                       wait_cnt_d = wait_cnt_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            mac_en_q   <= 1'b0;
            vec_q      <= '0;
            bias_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mac_en_q   <= fifo_pop;
            if (fifo_pop) vec_q <= fifo_rd_data[VEC_W-1:0];
            if (state_d == ST_CLEAR && state_q != ST_CLEAR) bias_q <= cfg_bias;
        end
    end

    assign DMA_channel_0 = vec_q[0*BEAT_W +: BEAT_W];
    assign DMA_channel_1 = vec_q[1*BEAT_W +: BEAT_W];
    assign DMA_channel_2 = vec_q[2*BEAT_W +: BEAT_W];
    assign DMA_channel_3 = vec_q[3*BEAT_W +: BEAT_W];
    assign mac_en        = mac_en_q;
    assign mac_clr       = (state_q == ST_CLEAR);
    assign mac_read_en   = (state_q == ST_WAIT) && (wait_cnt_q == LAT_CNT);
    assign bias          = bias_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
    assign err           = err_q;

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - self-checking bench for mac_feeder
module tb_mac_feeder;

    localparam int LAT  = 2;
    localparam int LAT2 = 15;
    localparam int NV   = 6;

    typedef struct {
        string           name;
        int              nb;
        logic [3:0][63:0] d;
        logic [15:0]     bias;
        logic [255:0]    exp_vec;
        logic            exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [63:0] s_data = '0;
    logic [15:0] cfg_bias = '0;
    logic        sel = 1'b0;

    logic        sv [2];
    logic        rdy_v [2];
    logic        en_v [2];
    logic        clr_v [2];
    logic        rd_v [2];
    logic        busy_v [2];
    logic        err_v [2];
    logic [15:0] bias_v [2];
    logic [63:0] ch_v [2][4];

    logic         m_ready, m_en, m_clr, m_rd, m_busy, m_err;
    logic [15:0]  m_bias;
    logic [255:0] m_vec;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int stalls = 0;

    int           q_en_cyc [$];
    logic [255:0] q_vec [$];
    int           q_clr_cyc [$];
    logic [15:0]  q_clr_bias [$];
    int           q_rd_cyc [$];
    logic [15:0]  q_rd_bias [$];

    vec_t tbl [NV];

    assign sv[0] = s_valid && !sel;
    assign sv[1] = s_valid && sel;

    assign m_ready = rdy_v[sel];
    assign m_en    = en_v[sel];
    assign m_clr   = clr_v[sel];
    assign m_rd    = rd_v[sel];
    assign m_busy  = busy_v[sel];
    assign m_err   = err_v[sel];
    assign m_bias  = bias_v[sel];
    assign m_vec   = {ch_v[sel][3], ch_v[sel][2], ch_v[sel][1], ch_v[sel][0]};

    mac_feeder dut (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_data(s_data), .s_last(s_last),
        .s_ready(rdy_v[0]), .cfg_bias(cfg_bias),
        .DMA_channel_0(ch_v[0][0]), .DMA_channel_1(ch_v[0][1]),
        .DMA_channel_2(ch_v[0][2]), .DMA_channel_3(ch_v[0][3]),
        .mac_en(en_v[0]), .mac_clr(clr_v[0]), .mac_read_en(rd_v[0]),
        .bias(bias_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );

    mac_feeder #(.READ_LAT(LAT2)) dut_bp (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_data(s_data), .s_last(s_last),
        .s_ready(rdy_v[1]), .cfg_bias(cfg_bias),
        .DMA_channel_0(ch_v[1][0]), .DMA_channel_1(ch_v[1][1]),
        .DMA_channel_2(ch_v[1][2]), .DMA_channel_3(ch_v[1][3]),
        .mac_en(en_v[1]), .mac_clr(clr_v[1]), .mac_read_en(rd_v[1]),
        .bias(bias_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_en || m_clr || m_rd)
                chk("mutex_pulses", 256'(int'(m_en) + int'(m_clr) + int'(m_rd)), 256'(1));
            if (m_clr) begin q_clr_cyc.push_back(cyc); q_clr_bias.push_back(m_bias); end
            if (m_en)  begin q_en_cyc.push_back(cyc);  q_vec.push_back(m_vec);       end
            if (m_rd)  begin q_rd_cyc.push_back(cyc);  q_rd_bias.push_back(m_bias);  end
        end
    end

    task automatic clear_mon();
        q_en_cyc.delete(); q_vec.delete(); q_clr_cyc.delete();
        q_clr_bias.delete(); q_rd_cyc.delete(); q_rd_bias.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l, input int idx);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        forever begin
            @(negedge clk);
            if (m_ready) break;
            stalls++;
            chk("stall_only_on_beat3", 256'(idx), 256'(3));
            n++;
            if (n > 300) begin
                chk("send_timeout", 256'(1), 256'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_vec(input logic [3:0][63:0] d, input int nb, input logic last);
        for (int i = 0; i < nb; i++) send_beat(d[i], last && (i == nb - 1), i);
    endtask

    task automatic wait_rd(input int n);
        int k = 0;
        while (q_rd_cyc.size() < n && k < 400) begin
            @(negedge clk); #1; k++;
        end
        chk("read_pulse_seen", 256'(q_rd_cyc.size()), 256'(n));
    endtask

    function automatic logic [3:0][63:0] mk(input int i);
        logic [3:0][63:0] d;
        for (int j = 0; j < 4; j++) d[j] = 64'hC000_0000_0000_0000 | 64'(i * 4 + j);
        return d;
    endfunction

    task automatic chk_zero_outputs(input string p);
        chk({p, "_s_ready"}, 256'(m_ready), 256'(0));
        chk({p, "_mac_en"},  256'(m_en),    256'(0));
        chk({p, "_mac_clr"}, 256'(m_clr),   256'(0));
        chk({p, "_read_en"}, 256'(m_rd),    256'(0));
        chk({p, "_busy"},    256'(m_busy),  256'(0));
        chk({p, "_err"},     256'(m_err),   256'(0));
        chk({p, "_bias"},    256'(m_bias),  256'(0));
        chk({p, "_chans"},   m_vec,         256'(0));
    endtask

    task automatic set_vec(input int t, input string nm, input int nb, input logic [3:0][63:0] d,
                           input logic [15:0] b, input logic [255:0] e, input logic er);
        tbl[t].name = nm; tbl[t].nb = nb; tbl[t].d = d;
        tbl[t].bias = b;  tbl[t].exp_vec = e; tbl[t].exp_err = er;
    endtask

    task automatic run_entry(input int t);
        int k;
        clear_mon();
        cfg_bias = tbl[t].bias;
        send_vec(tbl[t].d, tbl[t].nb, 1'b1);
        k = acc_cyc;
        wait_cycles(3);
        cfg_bias = ~tbl[t].bias;
        wait_rd(1);
        wait_cycles(2);
        chk({tbl[t].name, "_n_clr"}, 256'(q_clr_cyc.size()), 256'(1));
        chk({tbl[t].name, "_n_en"},  256'(q_en_cyc.size()),  256'(1));
        chk({tbl[t].name, "_err"},   256'(m_err),            256'(tbl[t].exp_err));
        chk({tbl[t].name, "_busy"},  256'(m_busy),           256'(0));
        if (q_clr_cyc.size() == 1 && q_en_cyc.size() == 1 && q_rd_cyc.size() == 1) begin
            chk({tbl[t].name, "_vec"},      q_vec[0],              tbl[t].exp_vec);
            chk({tbl[t].name, "_clr_bias"}, 256'(q_clr_bias[0]),   256'(tbl[t].bias));
            chk({tbl[t].name, "_rd_bias"},  256'(q_rd_bias[0]),    256'(tbl[t].bias));
            chk({tbl[t].name, "_rd_lat"},   256'(q_rd_cyc[0] - q_en_cyc[0]), 256'(LAT));
            chk_range({tbl[t].name, "_clr_lat"}, q_clr_cyc[0] - k, 1, 2);
            chk_range({tbl[t].name, "_en_lat"},  q_en_cyc[0] - k, 2, 3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][63:0] g;

        set_vec(0, "aaaa_full", 4, {4{64'hAAAA_AAAA_AAAA_AAAA}}, 16'h0010,
                {4{64'hAAAA_AAAA_AAAA_AAAA}}, 1'b0);
        set_vec(1, "ramp_full", 4, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'h1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0);
        set_vec(2, "short2", 2, {64'h0, 64'h0, 64'h2, 64'h1}, 16'h0055,
                {64'h0, 64'h0, 64'h2, 64'h1}, 1'b1);
        set_vec(3, "short1", 1, {64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_CAFE_F00D}, 16'hFFFF,
                {64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_CAFE_F00D}, 1'b1);
        set_vec(4, "short3", 3, {64'h0, 64'h7, 64'h6, 64'h5}, 16'h0001,
                {64'h0, 64'h7, 64'h6, 64'h5}, 1'b1);
        set_vec(5, "full_err_held", 4, {64'hB, 64'hA, 64'h9, 64'h8}, 16'h0002,
                {64'hB, 64'hA, 64'h9, 64'h8}, 1'b1);

        #1 rst_n = 1'b0;
        #11;
        chk_zero_outputs("reset");
        @(posedge clk); #2 rst_n = 1'b1;
        chk("ready_before_first_edge", 256'(m_ready), 256'(0));
        @(posedge clk); #1;
        chk("ready_after_first_edge", 256'(m_ready), 256'(1));

        for (int t = 0; t < NV; t++) run_entry(t);

        // three-vector group streamed without gaps
        clear_mon(); stalls = 0; cfg_bias = 16'h0BB8;
        for (int i = 0; i < 3; i++) send_vec(mk(i), 4, i == 2);
        wait_rd(1); wait_cycles(2);
        chk("b2b_n_en", 256'(q_en_cyc.size()), 256'(3));
        chk("b2b_n_clr", 256'(q_clr_cyc.size()), 256'(1));
        chk("b2b_stalls", 256'(stalls), 256'(0));
        if (q_en_cyc.size() == 3 && q_clr_cyc.size() == 1 && q_rd_cyc.size() == 1) begin
            for (int i = 0; i < 3; i++) chk("b2b_vec_order", q_vec[i], 256'(mk(i)));
            chk("b2b_clr_before_en", 256'(q_clr_cyc[0] < q_en_cyc[0]), 256'(1));
            chk("b2b_rd_lat", 256'(q_rd_cyc[0] - q_en_cyc[2]), 256'(LAT));
            chk("b2b_bias", 256'(q_rd_bias[0]), 256'(16'h0BB8));
        end

        // second group queued while the first sits in WAIT
        clear_mon(); cfg_bias = 16'h0100;
        send_vec(mk(10), 4, 1'b1);
        g = mk(11);
        send_beat(g[0], 1'b0, 0);
        send_beat(g[1], 1'b0, 1);
        cfg_bias = 16'h0200;
        send_beat(g[2], 1'b0, 2);
        send_beat(g[3], 1'b1, 3);
        wait_rd(2); wait_cycles(2);
        chk("q2_n_clr", 256'(q_clr_cyc.size()), 256'(2));
        if (q_clr_cyc.size() == 2 && q_rd_cyc.size() == 2 && q_en_cyc.size() == 2) begin
            chk("q2_clr_after_rd", 256'(q_clr_cyc[1] - q_rd_cyc[0]), 256'(1));
            chk("q2_bias_g1", 256'(q_rd_bias[0]), 256'(16'h0100));
            chk("q2_bias_g2_clr", 256'(q_clr_bias[1]), 256'(16'h0200));
            chk("q2_bias_g2_rd", 256'(q_rd_bias[1]), 256'(16'h0200));
            chk("q2_vec_g1", q_vec[0], 256'(mk(10)));
            chk("q2_vec_g2", q_vec[1], 256'(mk(11)));
        end

        // backpressure: long-latency instance stalls in WAIT while the FIFO fills
        sel = 1'b1; clear_mon(); stalls = 0;
        for (int i = 0; i < 5; i++) send_vec(mk(20 + i), 4, (i == 0) || (i == 4));
        wait_rd(2); wait_cycles(2);
        chk("bp_stall_seen", 256'(stalls > 0), 256'(1));
        chk("bp_n_en", 256'(q_en_cyc.size()), 256'(5));
        chk("bp_n_clr", 256'(q_clr_cyc.size()), 256'(2));
        if (q_en_cyc.size() == 5 && q_rd_cyc.size() == 2) begin
            for (int i = 0; i < 5; i++) chk("bp_vec_order", q_vec[i], 256'(mk(20 + i)));
            chk("bp_rd_lat", 256'(q_rd_cyc[0] - q_en_cyc[0]), 256'(LAT2));
        end
        sel = 1'b0;

        // reset in the middle of a running group, with a partial vector staged
        clear_mon();
        send_vec(mk(30), 4, 1'b0);
        send_vec(mk(31), 4, 1'b0);
        g = mk(32);
        send_beat(g[0], 1'b0, 0);
        send_beat(g[1], 1'b0, 1);
        chk("mid_run_en_before_reset", 256'(q_en_cyc.size()), 256'(2));
        #1 rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        clear_mon();
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        chk("rerelease_ready_low", 256'(m_ready), 256'(0));
        @(posedge clk); #1;
        chk("rerelease_ready_high", 256'(m_ready), 256'(1));
        wait_cycles(20);
        chk("post_reset_no_pulses",
            256'(q_en_cyc.size() + q_clr_cyc.size() + q_rd_cyc.size()), 256'(0));
        run_entry(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
